// File: rtl/counter_display_driver.sv
`default_nettype none
// ============================================================================
// Module : counter_display_driver
// Desc   : Serial binary-to-BCD converter feeding a multiplexed active-low
//          7-segment display with leading-zero blanking.
// Rev    : 1.0
// ============================================================================
module counter_display_driver #(
  parameter int N              = 4,
  parameter int DIGITS         = 4,
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [N-1:0]      value_in_i,
  input  logic              load_value_i,
  output logic              busy_o,
  output logic [DIGITS-1:0] anodes_o,
  output logic [6:0]        segments_o
);

  localparam int SW   = DIGITS * 4;
  localparam int CNTW = (N > 1) ? $clog2(N) : 1;
  localparam int RW   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      shift_q, shift_d;
  logic [SW-1:0]     scratch_q, scratch_d;
  logic [CNTW-1:0]   bitcnt_q, bitcnt_d;
  logic [SW-1:0]     disp_q, disp_d;
  logic [RW-1:0]     refresh_q, refresh_d;
  logic [DW-1:0]     digit_q, digit_d;
  logic [DIGITS-1:0] anodes_q, anodes_d;
  logic [6:0]        segments_q, segments_d;

  logic [SW-1:0]     w_adj;
  logic [SW+N-1:0]   w_cat;
  logic [DIGITS-1:0] w_upper_zero;
  logic [3:0]        w_nib;
  logic              w_blank;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Shift-add-3 step: correct nibbles >=5 before doubling so they carry as BCD.
  always_comb begin
    w_adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    w_cat = {w_adj, shift_q} << 1;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    bitcnt_d  = bitcnt_q;
    disp_d    = disp_q;
    case (state_q)
      ST_IDLE: begin
        if (load_value_i) begin
          shift_d   = value_in_i;
          scratch_d = '0;
          bitcnt_d  = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scratch_d = w_cat[SW+N-1:N];
        shift_d   = w_cat[N-1:0];
        bitcnt_d  = bitcnt_q + 1'b1;
        if (bitcnt_q == CNTW'(N - 1)) begin
          disp_d  = w_cat[SW+N-1:N];
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_blank
      assign w_upper_zero[g] = ~|disp_q[SW-1:4*g];
    end
  endgenerate

  // Outputs are built from the next digit index so anodes and segments
  // switch together on the same edge as the index itself.
  always_comb begin
    refresh_d = (refresh_q == RW'(REFRESH_CYCLES - 1)) ? '0 : refresh_q + 1'b1;
    digit_d   = digit_q;
    if (refresh_q == RW'(REFRESH_CYCLES - 1)) begin
      digit_d = (digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
    end
    w_nib    = 4'd0;
    w_blank  = 1'b0;
    anodes_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_d == DW'(i)) begin
        w_nib       = disp_q[4*i +: 4];
        w_blank     = (i != 0) && w_upper_zero[i];
        anodes_d[i] = 1'b0;
      end
    end
    segments_d = w_blank ? SEG_BLANK : decode(w_nib);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      bitcnt_q   <= '0;
      disp_q     <= '0;
      refresh_q  <= '0;
      digit_q    <= '0;
      anodes_q   <= {{(DIGITS-1){1'b1}}, 1'b0};
      segments_q <= 7'b1000000;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      bitcnt_q   <= bitcnt_d;
      disp_q     <= disp_d;
      refresh_q  <= refresh_d;
      digit_q    <= digit_d;
      anodes_q   <= anodes_d;
      segments_q <= segments_d;
    end
  end

  assign busy_o     = (state_q == ST_SHIFT);
  assign anodes_o   = anodes_q;
  assign segments_o = segments_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_display_driver.sv
`default_nettype none
// ============================================================================
// Module : tb_counter_display_driver
// Desc   : Scoreboard bench for three counter_display_driver configurations.
// Rev    : 1.0
// ============================================================================
module tb_counter_display_driver;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S5 = 7'b0010010, S7 = 7'b1111000,
                         S9 = 7'b0010000, BL = 7'b1111111;

  typedef struct packed {
    logic [1:0]      dut;
    logic [7:0]      blen;
    logic [3:0][6:0] seg;
  } exp_t;

  logic clk, rst;
  logic [3:0] v0;
  logic [7:0] v1, v2;
  logic ld0, ld1, ld2;
  logic bz0, bz1, bz2;
  logic [3:0] an0, an1;
  logic [1:0] an2;
  logic [6:0] sg0, sg1, sg2;

  logic       bz [3];
  logic [3:0] an [3];
  logic [6:0] sg [3];

  int   errors = 0;
  int   checks = 0;
  exp_t sb [$];
  int   blen [3];
  int   cap [3];
  logic prev [3];
  logic [6:0] got [3][4];
  logic [3:0] seen [3];
  exp_t cur [3];

  counter_display_driver #(.N(4), .DIGITS(4), .REFRESH_CYCLES(4)) u_dut0 (
    .clock_i(clk), .reset_i(rst), .value_in_i(v0), .load_value_i(ld0),
    .busy_o(bz0), .anodes_o(an0), .segments_o(sg0));
  counter_display_driver #(.N(8), .DIGITS(4), .REFRESH_CYCLES(4)) u_dut1 (
    .clock_i(clk), .reset_i(rst), .value_in_i(v1), .load_value_i(ld1),
    .busy_o(bz1), .anodes_o(an1), .segments_o(sg1));
  counter_display_driver #(.N(8), .DIGITS(2), .REFRESH_CYCLES(4)) u_dut2 (
    .clock_i(clk), .reset_i(rst), .value_in_i(v2), .load_value_i(ld2),
    .busy_o(bz2), .anodes_o(an2), .segments_o(sg2));

  assign bz[0] = bz0;
  assign bz[1] = bz1;
  assign bz[2] = bz2;
  assign an[0] = an0;
  assign an[1] = an1;
  assign an[2] = {2'b11, an2};
  assign sg[0] = sg0;
  assign sg[1] = sg1;
  assign sg[2] = sg2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: a falling busy marks a finished conversion; pop the expectation,
  // check the busy length, then watch one full scan and check every digit.
  always @(negedge clk) begin
    int nd, lit, lows;
    for (int d = 0; d < 3; d++) begin
      nd = (d == 2) ? 2 : 4;
      if (rst) begin
        blen[d] = 0;
        cap[d]  = 0;
        prev[d] = 1'b0;
      end else begin
        if (cap[d] > 0) begin
          lit  = 0;
          lows = 0;
          for (int i = 0; i < nd; i++) begin
            if (!an[d][i]) begin
              lows++;
              lit = i;
            end
          end
          checks++;
          if (lows != 1) begin
            errors++;
            $display("FAIL onehot dut%0d: anodes=%b, required exactly one low", d, an[d]);
          end else begin
            got[d][lit]  = sg[d];
            seen[d][lit] = 1'b1;
          end
          cap[d]--;
          if (cap[d] == 0) begin
            for (int i = 0; i < nd; i++) begin
              checks++;
              if (!seen[d][i] || got[d][i] !== cur[d].seg[i]) begin
                errors++;
                $display("FAIL digit dut%0d[%0d]: got=%b seen=%0b, required=%b",
                         d, i, got[d][i], seen[d][i], cur[d].seg[i]);
              end
            end
          end
        end
        if (bz[d]) begin
          blen[d]++;
        end else if (prev[d]) begin
          checks++;
          if (sb.size() == 0 || sb[0].dut != 2'(d)) begin
            errors++;
            $display("FAIL unexpected_done dut%0d: busy fell with no matching expectation", d);
          end else begin
            cur[d] = sb.pop_front();
            if (blen[d] != int'(cur[d].blen)) begin
              errors++;
              $display("FAIL busy_len dut%0d: got=%0d, required=%0d", d, blen[d], cur[d].blen);
            end
            cap[d]  = nd * 4;
            seen[d] = 4'b0;
          end
          blen[d] = 0;
        end
        prev[d] = bz[d];
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] g, input logic [7:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got=%b, required=%b", nm, g, e);
    end
  endtask

  task automatic push(input int d, input int bl, input logic [6:0] d3, input logic [6:0] d2,
                      input logic [6:0] d1, input logic [6:0] d0);
    exp_t e;
    e.dut  = 2'(d);
    e.blen = 8'(bl);
    e.seg  = {d3, d2, d1, d0};
    sb.push_back(e);
  endtask

  task automatic pulse(input int d, input logic [7:0] val);
    @(posedge clk); #1;
    case (d)
      0: begin v0 = val[3:0]; ld0 = 1'b1; end
      1: begin v1 = val; ld1 = 1'b1; end
      default: begin v2 = val; ld2 = 1'b1; end
    endcase
    @(posedge clk); #1;
    ld0 = 1'b0; ld1 = 1'b0; ld2 = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || cap[0] != 0 || cap[1] != 0 || cap[2] != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL timeout: got=%0d pending, required=0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    v0 = '0; v1 = '0; v2 = '0;
    ld0 = 1'b0; ld1 = 1'b0; ld2 = 1'b0;

    // 1: reset values and scan order
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {7'd0, bz0}, 8'd0);
    chk("reset_anodes", {4'd0, an0}, 8'b1110);
    chk("reset_segments", {1'b0, sg0}, {1'b0, S0});
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      chk($sformatf("scan0_k%0d", k), {4'd0, an0}, {4'd0, ~(4'b0001 << (k / 4))});
      chk($sformatf("scan2_k%0d", k), {6'd0, an2}, {6'd0, ~(2'b01 << ((k / 4) % 2))});
    end

    // 2: 15 on N=4
    push(0, 4, BL, BL, S1, S5);
    pulse(0, 8'd15);
    wait_idle();

    // 3: second load while busy is ignored
    push(0, 4, BL, BL, BL, S9);
    pulse(0, 8'd9);
    @(posedge clk); #1;
    v0 = 4'd7; ld0 = 1'b1;
    @(posedge clk); #1;
    ld0 = 1'b0;
    wait_idle();

    // 4: reset mid-conversion
    pulse(0, 8'd3);
    @(posedge clk); #1;
    chk("midconv_busy", {7'd0, bz0}, 8'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {7'd0, bz0}, 8'd0);
    chk("abort_anodes", {4'd0, an0}, 8'b1110);
    chk("abort_segments", {1'b0, sg0}, {1'b0, S0});
    @(posedge clk); #1;
    chk("abort_no_resume", {7'd0, bz0}, 8'd0);
    chk("abort_still_zero", {1'b0, sg0}, {1'b0, S0});

    push(0, 4, BL, BL, S1, S0);
    pulse(0, 8'd10);
    wait_idle();

    // 5: N=8, DIGITS=4
    push(1, 8, BL, S2, S5, S5);
    pulse(1, 8'd255);
    wait_idle();
    push(1, 8, BL, BL, BL, S0);
    pulse(1, 8'd0);
    wait_idle();
    push(1, 8, BL, S1, S0, S0);
    pulse(1, 8'd100);
    wait_idle();

    // 6: N=8, DIGITS=2 drops the hundreds digit
    push(2, 8, BL, BL, S2, S3);
    pulse(2, 8'd123);
    wait_idle();
    push(2, 8, BL, BL, BL, S7);
    pulse(2, 8'd207);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
